fwd_hazard_unit: RTL and testbench
==================================

Name: fwd_hazard_unit

Overview:
- Parametrised successor to the ID-stage forwarding logic.
- Keeps its own pipeline of destination tags (valid, rd, we, result source), one tag per stage from EX to WB, advancing in step with the datapath.
- For each ID read port, picks the youngest matching producer and forwards that stage's result only if the producer's source has reached its ready stage.
- Otherwise raises a load-use stall and inserts a bubble. x0 is never forwarded.

Parameters:
- XLEN, 32, data width.
- REG_ADDR_W, 4, register index width (RV32E).
- NUM_STAGES, 4, tracked stages after ID; index 0 = EX, NUM_STAGES-1 = WB.
- NUM_RD_PORTS, 2, ID operand read ports.
- MEM_READY_STAGE, 2, first stage index at which load data is valid (0..NUM_STAGES-1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs  in  NUM_RD_PORTS x REG_ADDR_W  source register indices.
- id_rs_used  in  NUM_RD_PORTS  port actually read by the instruction.
- id_rd  in  REG_ADDR_W  destination index of the ID instruction.
- id_we  in  1  ID instruction writes rd.
- id_rd_src  in  rd_src_e  result source: SRC_ALU, SRC_MEM, SRC_PC4.
- regfile_rs_data  in  NUM_RD_PORTS x XLEN  register file read data.
- stage_result  in  NUM_STAGES x XLEN  result carried by each stage (ALU, PC+4 or load data, per that stage's source).
- hold  in  1  back-end freeze; tags do not advance.
- flush  in  1  kill the ID instruction and the EX-stage tag.
- rs_data_id  out  NUM_RD_PORTS x XLEN  operand to ID.
- rs_forwarded  out  NUM_RD_PORTS  operand taken from a stage, not the regfile.
- stall_id  out  1  ID must not advance this cycle.

Behaviour:
- Reset (async, rst_n=0): all tag valids cleared. Outputs are then combinational defaults: stall_id=0, rs_forwarded=0, rs_data_id=regfile_rs_data.
- Match, per port p and stage k: tag[k].valid & tag[k].we & tag[k].rd==id_rs[p] & id_rs[p]!=0 & id_rs_used[p].
- Priority: lowest k (youngest) wins; older matches are ignored.
- Ready: a winning stage k is ready when k >= ready_stage(src), where ready_stage = 0 for SRC_ALU/SRC_PC4 and MEM_READY_STAGE for SRC_MEM.
- Winner ready: rs_data_id[p]=stage_result[k], rs_forwarded[p]=1.
- Winner not ready: stall_id=1, rs_forwarded[p]=0, rs_data_id[p]=regfile data (don't-care).
- No winner: regfile data, rs_forwarded[p]=0.
- stall_id = id_valid & !flush & (any port has an unready winner). Outputs are combinational, with no added latency.
- Tag advance on each rising clk when hold=0:
  - tag[k] <= tag[k-1] for k=1..NUM_STAGES-1.
  - tag[0] <= id tag if (id_valid & !stall_id & !flush), else bubble (valid=0).
  - The WB tag retires; the regfile must hold that value from the next cycle.
- hold=1: all tags frozen; stall_id is still evaluated normally.
- flush=1: tag[0] is cleared on the edge even if hold=1; the ID instruction is not captured.
- flush and hold together: stage 0 cleared, stages 1.. frozen.
- Reset asserted mid-operation clears all tags immediately; no pending stall survives reset.
- A load whose winner is at k < MEM_READY_STAGE stalls for exactly MEM_READY_STAGE-k cycles, assuming hold=0.

Optional Feature:
- Macro: FWD_HAZARD_PERF_CNT_EN.
- Defined: adds outputs perf_stall_cycles and perf_fwd_count, each 32 bits, reset to 0 and wrapping modulo 2^32.
  - perf_stall_cycles increments each cycle with stall_id=1 & hold=0.
  - perf_fwd_count increments by the number of ports with rs_forwarded=1 in cycles where ID advances (id_valid & !stall_id & !flush & !hold).
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package fwd_pkg:
  - rd_src_e enum (SRC_ALU, SRC_MEM, SRC_PC4).
  - fwd_tag_t struct {valid, we, rd, src}.
  - ready_stage() function.
  - Constant REG_ZERO=0.
- Sub-module fwd_port_select: one instance per read port, implementing the priority search, ready check and mux over the NUM_STAGES tags.
- The tag shift register and stall logic stay in the top module.

Test Plan:
- ALU back-to-back: issue x5=ALU (tag to EX), then an instruction reading x5, with stage_result[0]=0x1234 -> rs_data_id[0]=0x1234, rs_forwarded[0]=1, stall_id=0.
- Load-use (MEM_READY_STAGE=2): load x3, then an instruction reading x3 -> stall_id=1 for 2 cycles with bubbles in EX; 3rd cycle gets stage_result[2], rs_forwarded=1.
- Priority: x7 in EX (0xA) and x7 in WB (0xB) -> operand 0xA. x0 target in EX with rs=0 -> regfile data, rs_forwarded=0.
- hold=1 for 3 cycles during a load-use stall -> tags frozen, stall_id stays 1; release -> stall resolves after the remaining cycles.
- flush with a valid ID write to x4 -> next cycle an x4 reader gets no forward from EX, and the EX tag is invalid.
- rst_n pulsed low mid-stall -> stall_id=0, no forwards the cycle after release. With FWD_HAZARD_PERF_CNT_EN, counters read 0.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared types for the ID-stage forwarding / hazard unit: result-source
// encoding, the per-stage destination tag and the ready-stage lookup.
package fwd_pkg;

    // Tag rd field is sized for the widest supported register file (RV32I);
    // narrower indices (RV32E) are zero-extended into it.
    localparam int TAG_RD_W = 5;

    localparam logic [TAG_RD_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        SRC_ALU = 2'd0,
        SRC_MEM = 2'd1,
        SRC_PC4 = 2'd2
    } rd_src_e;

    typedef struct packed {
        logic                valid;
        logic                we;
        logic [TAG_RD_W-1:0] rd;
        rd_src_e             src;
    } fwd_tag_t;

    // First stage index at which a producer of the given source has its result.
    function automatic int unsigned ready_stage(input rd_src_e src,
                                                input int unsigned mem_ready_stage);
        int unsigned stage;
        case (src)
            SRC_ALU: stage = 32'd0;
            SRC_PC4: stage = 32'd0;
            SRC_MEM: stage = mem_ready_stage;
            default: stage = 32'd0;
        endcase
        return stage;
    endfunction

endpackage

// File: rtl/fwd_port_select.sv
// Per-read-port forwarding selector: finds the youngest tracked stage that
// writes the requested register, checks whether its result is available yet,
// and muxes either that stage's result or the regfile data.
module fwd_port_select
    import fwd_pkg::*;
#(
    parameter int XLEN            = 32,
    parameter int NUM_STAGES      = 4,
    parameter int MEM_READY_STAGE = 2
) (
    input  fwd_tag_t                         i_tags [NUM_STAGES],
    input  logic [TAG_RD_W-1:0]              i_rs,
    input  logic                             i_rs_used,
    input  logic [XLEN-1:0]                  i_rf_data,
    input  logic [NUM_STAGES-1:0][XLEN-1:0]  i_stage_result,
    output logic [XLEN-1:0]                  o_rs_data,
    output logic                             o_fwd,
    output logic                             o_unready
);

    localparam int SEL_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    logic [NUM_STAGES-1:0] w_match;
    logic [SEL_W-1:0]      w_sel;
    logic                  w_hit;
    logic                  w_ready;

    // Priority search: scanning oldest to youngest lets the youngest match win.
    always_comb begin
        w_match = '0;
        w_sel   = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            w_match[k] = i_tags[k].valid & i_tags[k].we & (i_tags[k].rd == i_rs) &
                         (i_rs != REG_ZERO) & i_rs_used;
        end
        for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            w_sel = w_match[k] ? SEL_W'(k) : w_sel;
        end
        w_hit   = |w_match;
        w_ready = (32'(w_sel) >= ready_stage(i_tags[w_sel].src, 32'(MEM_READY_STAGE)));
    end

    // Operand mux: forward a ready winner, otherwise fall back to the regfile.
    always_comb begin
        o_rs_data = i_rf_data;
        o_fwd     = 1'b0;
        o_unready = 1'b0;
        if (w_hit && w_ready) begin
            o_rs_data = i_stage_result[w_sel];
            o_fwd     = 1'b1;
        end else if (w_hit) begin
            o_unready = 1'b1;
        end else begin
            o_fwd     = 1'b0;
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// ID-stage forwarding and load-use hazard unit. Tracks one destination tag per
// stage from EX to WB, forwards the youngest ready producer per read port and
// raises stall_id when a producer's result is not yet available.
// Optional build macro FWD_HAZARD_PERF_CNT_EN adds stall/forward counters.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int XLEN            = 32,
    parameter int REG_ADDR_W      = 4,
    parameter int NUM_STAGES      = 4,
    parameter int NUM_RD_PORTS    = 2,
    parameter int MEM_READY_STAGE = 2
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                id_valid,
    input  logic [NUM_RD_PORTS-1:0][REG_ADDR_W-1:0] id_rs,
    input  logic [NUM_RD_PORTS-1:0]             id_rs_used,
    input  logic [REG_ADDR_W-1:0]               id_rd,
    input  logic                                id_we,
    input  rd_src_e                             id_rd_src,
    input  logic [NUM_RD_PORTS-1:0][XLEN-1:0]   regfile_rs_data,
    input  logic [NUM_STAGES-1:0][XLEN-1:0]     stage_result,
    input  logic                                hold,
    input  logic                                flush,
    output logic [NUM_RD_PORTS-1:0][XLEN-1:0]   rs_data_id,
    output logic [NUM_RD_PORTS-1:0]             rs_forwarded,
`ifdef FWD_HAZARD_PERF_CNT_EN
    output logic [31:0]                         perf_stall_cycles,
    output logic [31:0]                         perf_fwd_count,
`endif
    output logic                                stall_id
);

    fwd_tag_t                  r_tags [NUM_STAGES];
    fwd_tag_t                  w_id_tag;
    logic [NUM_RD_PORTS-1:0]   w_unready;
    logic                      w_advance;

    assign w_id_tag  = '{valid: 1'b1, we: id_we, rd: TAG_RD_W'(id_rd), src: id_rd_src};
    assign stall_id  = id_valid & ~flush & (|w_unready);
    assign w_advance = id_valid & ~stall_id & ~flush;

    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_port
        fwd_port_select #(
            .XLEN            (XLEN),
            .NUM_STAGES      (NUM_STAGES),
            .MEM_READY_STAGE (MEM_READY_STAGE)
        ) u_sel (
            .i_tags         (r_tags),
            .i_rs           (TAG_RD_W'(id_rs[p])),
            .i_rs_used      (id_rs_used[p]),
            .i_rf_data      (regfile_rs_data[p]),
            .i_stage_result (stage_result),
            .o_rs_data      (rs_data_id[p]),
            .o_fwd          (rs_forwarded[p]),
            .o_unready      (w_unready[p])
        );
    end

    // EX tag: capture an advancing ID instruction, bubble otherwise; flush wins over hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tags[0] <= '0;
        end else if (flush) begin
            r_tags[0] <= '0;
        end else if (!hold) begin
            r_tags[0] <= w_advance ? w_id_tag : fwd_tag_t'('0);
        end else begin
            r_tags[0] <= r_tags[0];
        end
    end

    // Older tags shift one stage per cycle unless the back end is frozen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 1; k < NUM_STAGES; k++) r_tags[k] <= '0;
        end else if (!hold) begin
            for (int k = 1; k < NUM_STAGES; k++) r_tags[k] <= r_tags[k-1];
        end else begin
            for (int k = 1; k < NUM_STAGES; k++) r_tags[k] <= r_tags[k];
        end
    end

`ifdef FWD_HAZARD_PERF_CNT_EN
    logic [31:0] r_perf_stall_cycles;
    logic [31:0] r_perf_fwd_count;
    logic [31:0] w_fwd_ports;

    // Count forwarded operands for the current ID instruction.
    always_comb begin
        w_fwd_ports = 32'd0;
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            w_fwd_ports = w_fwd_ports + 32'(rs_forwarded[p]);
        end
    end

    // Free-running wrap-around counters for stall cycles and forwarded operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_stall_cycles <= 32'd0;
            r_perf_fwd_count    <= 32'd0;
        end else begin
            r_perf_stall_cycles <= r_perf_stall_cycles + 32'(stall_id & ~hold);
            r_perf_fwd_count    <= (w_advance & ~hold) ? (r_perf_fwd_count + w_fwd_ports)
                                                       : r_perf_fwd_count;
        end
    end

    assign perf_stall_cycles = r_perf_stall_cycles;
    assign perf_fwd_count    = r_perf_fwd_count;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit: stimulus pushes hand-computed
// expectations, a negedge monitor pops and compares them.
module tb_fwd_hazard_unit;
    import fwd_pkg::*;

    localparam logic [31:0] RF0 = 32'hAAAA_0000;
    localparam logic [31:0] RF1 = 32'hAAAA_0001;

    logic                 clk;
    logic                 rst_n;
    logic                 id_valid;
    logic [1:0][3:0]      id_rs;
    logic [1:0]           id_rs_used;
    logic [3:0]           id_rd;
    logic                 id_we;
    rd_src_e              id_rd_src;
    logic [1:0][31:0]     regfile_rs_data;
    logic [3:0][31:0]     stage_result;
    logic                 hold;
    logic                 flush;
    logic [1:0][31:0]     rs_data_id;
    logic [1:0]           rs_forwarded;
    logic                 stall_id;
`ifdef FWD_HAZARD_PERF_CNT_EN
    logic [31:0]          perf_stall_cycles;
    logic [31:0]          perf_fwd_count;
`endif

    fwd_hazard_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_valid        (id_valid),
        .id_rs           (id_rs),
        .id_rs_used      (id_rs_used),
        .id_rd           (id_rd),
        .id_we           (id_we),
        .id_rd_src       (id_rd_src),
        .regfile_rs_data (regfile_rs_data),
        .stage_result    (stage_result),
        .hold            (hold),
        .flush           (flush),
        .rs_data_id      (rs_data_id),
        .rs_forwarded    (rs_forwarded),
`ifdef FWD_HAZARD_PERF_CNT_EN
        .perf_stall_cycles (perf_stall_cycles),
        .perf_fwd_count    (perf_fwd_count),
`endif
        .stall_id        (stall_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        stall;
        logic [1:0]  fwd;
        logic [1:0]  chk_d;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        chk_perf;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: compare one queued expectation per cycle, away from the active edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                check({e.name, ".stall"}, 32'(stall_id), 32'(e.stall));
                check({e.name, ".fwd"}, 32'(rs_forwarded), 32'(e.fwd));
                if (e.chk_d[0]) check({e.name, ".d0"}, rs_data_id[0], e.d0);
                if (e.chk_d[1]) check({e.name, ".d1"}, rs_data_id[1], e.d1);
`ifdef FWD_HAZARD_PERF_CNT_EN
                if (e.chk_perf) begin
                    check({e.name, ".perf_stall"}, perf_stall_cycles, 32'd0);
                    check({e.name, ".perf_fwd"}, perf_fwd_count, 32'd0);
                end
`endif
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [3:0] rs0, input logic [3:0] rs1,
                          input logic [1:0] used, input logic [3:0] rd, input logic we,
                          input rd_src_e src);
        id_valid = v; id_rs[0] = rs0; id_rs[1] = rs1; id_rs_used = used;
        id_rd = rd; id_we = we; id_rd_src = src;
    endtask

    task automatic expect_out(input string name, input logic stall, input logic [1:0] fwd,
                              input logic [1:0] chk_d, input logic [31:0] d0,
                              input logic [31:0] d1, input logic chk_perf);
        exp_t e;
        e.name = name; e.stall = stall; e.fwd = fwd; e.chk_d = chk_d;
        e.d0 = d0; e.d1 = d1; e.chk_perf = chk_perf;
        q.push_back(e);
    endtask

    task automatic drain();
        set_id(1'b0, 4'd0, 4'd0, 2'b00, 4'd0, 1'b0, SRC_ALU);
        hold = 1'b0; flush = 1'b0;
        for (int i = 0; i < 5; i++) step();
    endtask

    initial begin
        rst_n = 1'b0; hold = 1'b0; flush = 1'b0;
        regfile_rs_data[0] = RF0; regfile_rs_data[1] = RF1;
        stage_result = {32'h5000_0003, 32'h5000_0002, 32'h5000_0001, 32'h5000_0000};
        set_id(1'b0, 4'd0, 4'd0, 2'b00, 4'd0, 1'b0, SRC_ALU);

        // Reset state
        step();
        set_id(1'b1, 4'd5, 4'd6, 2'b11, 4'd0, 1'b0, SRC_ALU);
        expect_out("reset", 1'b0, 2'b00, 2'b11, RF0, RF1, 1'b1);
        step(); rst_n = 1'b1;
        drain();

        // ALU back-to-back
        set_id(1'b1, 4'd1, 4'd2, 2'b00, 4'd5, 1'b1, SRC_ALU);
        expect_out("alu_issue", 1'b0, 2'b00, 2'b11, RF0, RF1, 1'b0);
        step(); stage_result[0] = 32'h0000_1234;
        set_id(1'b1, 4'd5, 4'd0, 2'b01, 4'd0, 1'b0, SRC_ALU);
        expect_out("alu_ex", 1'b0, 2'b01, 2'b11, 32'h0000_1234, RF1, 1'b0);
        step(); stage_result[1] = 32'h0000_2222;
        set_id(1'b1, 4'd5, 4'd5, 2'b11, 4'd0, 1'b0, SRC_ALU);
        expect_out("alu_mem_both", 1'b0, 2'b11, 2'b11, 32'h0000_2222, 32'h0000_2222, 1'b0);
        step(); drain();

        // Load-use: two stall cycles, then forward from stage 2
        set_id(1'b1, 4'd0, 4'd0, 2'b00, 4'd3, 1'b1, SRC_MEM);
        expect_out("ld_issue", 1'b0, 2'b00, 2'b11, RF0, RF1, 1'b0);
        step(); stage_result[2] = 32'h0000_3333;
        set_id(1'b1, 4'd1, 4'd3, 2'b10, 4'd6, 1'b1, SRC_ALU);
        expect_out("ld_stall1", 1'b1, 2'b00, 2'b01, RF0, RF1, 1'b0);
        step();
        expect_out("ld_stall2", 1'b1, 2'b00, 2'b01, RF0, RF1, 1'b0);
        step();
        expect_out("ld_fwd", 1'b0, 2'b10, 2'b11, RF0, 32'h0000_3333, 1'b0);
        step(); drain();

        // Priority: youngest x7 wins; x0 never forwarded
        stage_result = {32'h0000_000B, 32'h0000_0022, 32'h0000_0011, 32'h0000_000A};
        set_id(1'b1, 4'd0, 4'd0, 2'b00, 4'd7, 1'b1, SRC_ALU); step();
        set_id(1'b1, 4'd0, 4'd0, 2'b00, 4'd1, 1'b0, SRC_ALU); step();
        step();
        set_id(1'b1, 4'd0, 4'd0, 2'b00, 4'd7, 1'b1, SRC_ALU); step();
        set_id(1'b1, 4'd7, 4'd0, 2'b01, 4'd0, 1'b1, SRC_ALU);
        expect_out("prio_ex_over_wb", 1'b0, 2'b01, 2'b11, 32'h0000_000A, RF1, 1'b0);
        step();
        set_id(1'b1, 4'd0, 4'd7, 2'b11, 4'd1, 1'b0, SRC_ALU);
        expect_out("prio_x0", 1'b0, 2'b10, 2'b11, RF0, 32'h0000_0011, 1'b0);
        step(); step();
        set_id(1'b1, 4'd7, 4'd0, 2'b11, 4'd1, 1'b0, SRC_ALU);
        expect_out("prio_wb_only", 1'b0, 2'b01, 2'b11, 32'h0000_000B, RF0 | 32'd0 | RF1, 1'b0);
        step(); drain();

        // Hold during a load-use stall
        stage_result[2] = 32'h0000_4444;
        set_id(1'b1, 4'd0, 4'd0, 2'b00, 4'd3, 1'b1, SRC_MEM); step();
        set_id(1'b1, 4'd3, 4'd0, 2'b01, 4'd0, 1'b0, SRC_ALU);
        expect_out("hold_pre", 1'b1, 2'b00, 2'b10, RF0, RF1, 1'b0);
        step(); hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            expect_out("hold_frozen", 1'b1, 2'b00, 2'b10, RF0, RF1, 1'b0);
            step();
        end
        hold = 1'b0;
        expect_out("hold_release", 1'b1, 2'b00, 2'b10, RF0, RF1, 1'b0);
        step();
        expect_out("hold_fwd", 1'b0, 2'b01, 2'b11, 32'h0000_4444, RF1, 1'b0);
        step(); drain();

        // Flush: ID write not captured; flush with hold clears EX only
        flush = 1'b1;
        set_id(1'b1, 4'd0, 4'd0, 2'b00, 4'd4, 1'b1, SRC_ALU);
        expect_out("flush_issue", 1'b0, 2'b00, 2'b11, RF0, RF1, 1'b0);
        step(); flush = 1'b0;
        set_id(1'b1, 4'd4, 4'd0, 2'b01, 4'd0, 1'b0, SRC_ALU);
        expect_out("flush_no_ex", 1'b0, 2'b00, 2'b11, RF0, RF1, 1'b0);
        step();
        set_id(1'b1, 4'd0, 4'd0, 2'b00, 4'd4, 1'b1, SRC_ALU); step();
        hold = 1'b1; flush = 1'b1;
        set_id(1'b1, 4'd0, 4'd0, 2'b00, 4'd8, 1'b1, SRC_ALU); step();
        hold = 1'b0; flush = 1'b0;
        set_id(1'b1, 4'd4, 4'd4, 2'b11, 4'd0, 1'b0, SRC_ALU);
        expect_out("flush_hold", 1'b0, 2'b00, 2'b11, RF0, RF1, 1'b0);
        step(); drain();
        set_id(1'b1, 4'd0, 4'd0, 2'b00, 4'd9, 1'b1, SRC_MEM); step();
        flush = 1'b1;
        set_id(1'b1, 4'd9, 4'd0, 2'b01, 4'd0, 1'b0, SRC_ALU);
        expect_out("flush_masks_stall", 1'b0, 2'b00, 2'b10, RF0, RF1, 1'b0);
        step(); flush = 1'b0;
        expect_out("flush_stall_after", 1'b1, 2'b00, 2'b10, RF0, RF1, 1'b0);
        step(); drain();

        // Reset mid-stall
        set_id(1'b1, 4'd0, 4'd0, 2'b00, 4'd3, 1'b1, SRC_MEM); step();
        set_id(1'b1, 4'd0, 4'd3, 2'b10, 4'd0, 1'b0, SRC_ALU);
        expect_out("rst_pre", 1'b1, 2'b00, 2'b01, RF0, RF1, 1'b0);
        step(); rst_n = 1'b0;
        expect_out("rst_mid", 1'b0, 2'b00, 2'b11, RF0, RF1, 1'b1);
        step(); rst_n = 1'b1;
        expect_out("rst_after", 1'b0, 2'b00, 2'b11, RF0, RF1, 1'b1);
        step();

        // Wait (bounded) for the monitor to consume everything.
        for (int i = 0; i < 20 && q.size() > 0; i++) step();
        if (q.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
